s32x_fb_arbiter: RTL and testbench

- Single-port sequencer for one 32X framebuffer DRAM bank.
- Shares the bank between five requesters: refresh window, display fetch, auto-fill engine, CPU write FIFO drain, and CPU direct read.
- Enforces fixed access timing in CE_R ticks and applies overwrite-mode zero-byte masking on FIFO writes.
- Sits between the VDP register/FIFO logic and the FB0/FB1 swap multiplexer.

---
 rtl/s32x_fb_arbiter_pkg.sv | 38 +++
 rtl/s32x_fb_wemask.sv | 13 +
 rtl/s32x_fb_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_s32x_fb_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s32x_fb_arbiter_pkg.sv
// Shared types for the 32X framebuffer bank sequencer: grant owner, sequencer state,
// FIFO write request bundle and the overwrite-mode byte mask rule.
package s32x_fb_arbiter_pkg;

  localparam int unsigned FB_AW = 16;

  typedef enum logic [2:0] {
    OWN_NONE = 3'd0,
    OWN_DISP = 3'd1,
    OWN_FILL = 3'd2,
    OWN_WR   = 3'd3,
    OWN_RD   = 3'd4
  } fb_owner_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_REFRESH = 2'd2
  } fb_arb_state_t;

  typedef struct packed {
    logic [FB_AW-1:0] a;
    logic [15:0]      d;
    logic [1:0]       be;
    logic             ovl;
  } fb_wr_req_t;

  // Overwrite-image writes never store a zero byte; normal writes follow the byte enables.
  function automatic logic [1:0] fb_we_mask(input logic [1:0] be, input logic [15:0] d,
                                            input logic ovl);
    logic hi_ok;
    logic lo_ok;
    hi_ok = ovl ? (|d[15:8]) : 1'b1;
    lo_ok = ovl ? (|d[7:0])  : 1'b1;
    return {be[1] & hi_ok, be[0] & lo_ok};
  endfunction

endpackage

// File: rtl/s32x_fb_wemask.sv
// Combinational byte-strobe generator for CPU FIFO writes, honouring overwrite mode.
module s32x_fb_wemask
  import s32x_fb_arbiter_pkg::*;
(
  input  logic [15:0] d_i,
  input  logic [1:0]  be_i,
  input  logic        ovl_i,
  output logic [1:0]  we_o
);

  assign we_o = fb_we_mask(be_i, d_i, ovl_i);

endmodule

// File: rtl/s32x_fb_arbiter.sv
// Single-port sequencer for one 32X framebuffer DRAM bank: fixed-priority arbitration
// between refresh, display, fill, FIFO write and CPU read, with CE_R-timed accesses.
module s32x_fb_arbiter
  import s32x_fb_arbiter_pkg::*;
#(
  parameter int unsigned ACC_CYC = 3,
  parameter int unsigned REF_CYC = 40,
  parameter int unsigned AW      = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ce_r_i,
  input  logic          ref_req_i,
  input  logic          disp_req_i,
  input  logic [AW-1:0] disp_a_i,
  output logic          disp_ack_o,
  output logic [15:0]   disp_q_o,
  input  logic          fill_req_i,
  input  logic [AW-1:0] fill_a_i,
  input  logic [15:0]   fill_d_i,
  output logic          fill_ack_o,
  input  logic          wr_req_i,
  input  logic [AW-1:0] wr_a_i,
  input  logic [15:0]   wr_d_i,
  input  logic [1:0]    wr_be_i,
  input  logic          wr_ovl_i,
  output logic          wr_ack_o,
  input  logic          rd_req_i,
  input  logic [AW-1:0] rd_a_i,
  output logic [15:0]   rd_q_o,
  output logic          rd_ack_o,
  output logic [AW-1:0] fb_a_o,
  output logic [15:0]   fb_do_o,
  output logic [1:0]    fb_we_o,
  output logic          fb_rd_o,
  input  logic [15:0]   fb_di_i,
  output logic          fen_o
);

  localparam int unsigned   CNT_MAX  = (REF_CYC > ACC_CYC) ? REF_CYC : ACC_CYC;
  localparam int unsigned   CW       = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] CNT_ACC  = CW'(ACC_CYC - 1);
  localparam logic [CW-1:0] CNT_REF  = CW'(REF_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  fb_arb_state_t state_q, state_d;
  fb_owner_t     owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ref_pend_q, ref_pend_d;
  logic [AW-1:0] fb_a_q, fb_a_d;
  logic [15:0]   fb_do_q, fb_do_d;
  logic [1:0]    fb_we_q, fb_we_d;
  logic          fb_rd_q, fb_rd_d;
  logic [15:0]   disp_q_q, disp_q_d;
  logic [15:0]   rd_q_q, rd_q_d;
  logic          disp_ack_q, disp_ack_d;
  logic          fill_ack_q, fill_ack_d;
  logic          wr_ack_q, wr_ack_d;
  logic          rd_ack_q, rd_ack_d;
  logic          fen_q, fen_d;

  fb_wr_req_t    wr_req_s;
  logic [1:0]    wr_we_s;
  logic          ack_busy_s;

  assign wr_req_s   = '{a: FB_AW'(wr_a_i), d: wr_d_i, be: wr_be_i, ovl: wr_ovl_i};
  // A requester still sees its ack this cycle, so its level must not win a fresh grant.
  assign ack_busy_s = disp_ack_q | fill_ack_q | wr_ack_q | rd_ack_q;

  s32x_fb_wemask u_wemask (
    .d_i   (wr_req_s.d),
    .be_i  (wr_req_s.be),
    .ovl_i (wr_req_s.ovl),
    .we_o  (wr_we_s)
  );

  // Arbitration, access/refresh timing and completion handling.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    ref_pend_d = ref_pend_q | ref_req_i;
    fb_a_d     = fb_a_q;
    fb_do_d    = fb_do_q;
    fb_we_d    = fb_we_q;
    fb_rd_d    = fb_rd_q;
    disp_q_d   = disp_q_q;
    rd_q_d     = rd_q_q;
    disp_ack_d = 1'b0;
    fill_ack_d = 1'b0;
    wr_ack_d   = 1'b0;
    rd_ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ce_r_i && !ack_busy_s) begin
          if (ref_pend_q) begin
            state_d    = ST_REFRESH;
            cnt_d      = CNT_REF;
            ref_pend_d = ref_req_i;
          end else if (disp_req_i) begin
            state_d = ST_ACCESS;
            owner_d = OWN_DISP;
            cnt_d   = CNT_ACC;
            fb_a_d  = disp_a_i;
            fb_rd_d = 1'b1;
            fb_we_d = 2'b00;
          end else if (fill_req_i) begin
            state_d = ST_ACCESS;
            owner_d = OWN_FILL;
            cnt_d   = CNT_ACC;
            fb_a_d  = fill_a_i;
            fb_do_d = fill_d_i;
            fb_rd_d = 1'b0;
            fb_we_d = 2'b11;
          end else if (wr_req_i) begin
            state_d = ST_ACCESS;
            owner_d = OWN_WR;
            cnt_d   = CNT_ACC;
            fb_a_d  = AW'(wr_req_s.a);
            fb_do_d = wr_req_s.d;
            fb_rd_d = 1'b0;
            fb_we_d = wr_we_s;
          end else if (rd_req_i) begin
            state_d = ST_ACCESS;
            owner_d = OWN_RD;
            cnt_d   = CNT_ACC;
            fb_a_d  = rd_a_i;
            fb_rd_d = 1'b1;
            fb_we_d = 2'b00;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (ce_r_i) begin
          if (cnt_q == CNT_ZERO) begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
            fb_rd_d = 1'b0;
            fb_we_d = 2'b00;
            case (owner_q)
              OWN_DISP: begin
                disp_q_d   = fb_di_i;
                disp_ack_d = 1'b1;
              end
              OWN_FILL: fill_ack_d = 1'b1;
              OWN_WR:   wr_ack_d   = 1'b1;
              OWN_RD: begin
                rd_q_d   = fb_di_i;
                rd_ack_d = 1'b1;
              end
              default:  owner_d = OWN_NONE;
            endcase
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_REFRESH: begin
        if (ce_r_i) begin
          if (cnt_q == CNT_ZERO) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        fb_rd_d = 1'b0;
        fb_we_d = 2'b00;
      end
    endcase
    fen_d = (state_d == ST_REFRESH) || (owner_d == OWN_FILL);
  end

  // State and output registers; reset aborts any access without acking it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_NONE;
      cnt_q      <= CNT_ZERO;
      ref_pend_q <= 1'b0;
      fb_a_q     <= {AW{1'b0}};
      fb_do_q    <= 16'h0000;
      fb_we_q    <= 2'b00;
      fb_rd_q    <= 1'b0;
      disp_q_q   <= 16'h0000;
      rd_q_q     <= 16'h0000;
      disp_ack_q <= 1'b0;
      fill_ack_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      fen_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      ref_pend_q <= ref_pend_d;
      fb_a_q     <= fb_a_d;
      fb_do_q    <= fb_do_d;
      fb_we_q    <= fb_we_d;
      fb_rd_q    <= fb_rd_d;
      disp_q_q   <= disp_q_d;
      rd_q_q     <= rd_q_d;
      disp_ack_q <= disp_ack_d;
      fill_ack_q <= fill_ack_d;
      wr_ack_q   <= wr_ack_d;
      rd_ack_q   <= rd_ack_d;
      fen_q      <= fen_d;
    end
  end

  assign fb_a_o     = fb_a_q;
  assign fb_do_o    = fb_do_q;
  assign fb_we_o    = fb_we_q;
  assign fb_rd_o    = fb_rd_q;
  assign disp_q_o   = disp_q_q;
  assign rd_q_o     = rd_q_q;
  assign disp_ack_o = disp_ack_q;
  assign fill_ack_o = fill_ack_q;
  assign wr_ack_o   = wr_ack_q;
  assign rd_ack_o   = rd_ack_q;
  assign fen_o      = fen_q;

endmodule

// File: tb/tb_s32x_fb_arbiter.sv
// Self-checking bench for s32x_fb_arbiter: directed scenarios, a write-mask vector table
// and randomized request bursts checked against a transaction-level priority model.
module tb_s32x_fb_arbiter;

  localparam int AW = 16;

  typedef struct {
    int          who;   // 0=DISP 1=FILL 2=WR 3=RD
    logic [15:0] a;
    logic [15:0] q;
    logic [15:0] dov;
    logic [1:0]  we;
    logic        rd;
    int          tick;
  } ack_t;

  typedef struct {
    logic        ovl;
    logic [1:0]  be;
    logic [15:0] d;
    logic [1:0]  we;
  } wv_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;
  logic ref_req, disp_req, fill_req, wr_req, rd_req, wr_ovl;
  logic [AW-1:0] disp_a, fill_a, wr_a, rd_a;
  logic [15:0] fill_d, wr_d;
  logic [1:0] wr_be;
  logic disp_ack, fill_ack, wr_ack, rd_ack, fb_rd, fen;
  logic [15:0] disp_q, rd_q, fb_do, fb_di;
  logic [AW-1:0] fb_a;
  logic [1:0] fb_we;

  logic di_ovr_en = 1'b0;
  logic [15:0] di_ovr = 16'h0000;
  int ce_div = 2;
  bit ce_rand = 1'b0;
  int ce_cnt = 0;

  int checks = 0;
  int errors = 0;
  int tick = 0, rd_ticks = 0, fen_ticks = 0, fen_viol = 0;
  logic [1:0] seen_we = 2'b00;
  logic seen_rd = 1'b0;
  bit hold_disp = 1'b0;
  ack_t ackq[$];

  always #5 clk = ~clk;

  // CE_R changes shortly after each rising edge so it is stable at the next one.
  always @(posedge clk) begin
    #2;
    if (ce_rand) ce = 1'($urandom_range(0, 1));
    else ce = ((ce_cnt % ce_div) == 0);
    ce_cnt++;
  end

  function automatic logic [15:0] dram_fn(input logic [15:0] a);
    return {a[7:0] ^ 8'h5A, a[15:8]};
  endfunction

  // A byte is stored if enabled, unless this is an overwrite write of a zero byte.
  function automatic logic [1:0] ref_we(input logic [1:0] be, input logic [15:0] d, input logic ovl);
    logic up, lo;
    up = be[1] && (!ovl || d[15:8] != 8'h00);
    lo = be[0] && (!ovl || d[7:0] != 8'h00);
    return {up, lo};
  endfunction

  assign fb_di = di_ovr_en ? di_ovr : dram_fn(fb_a);

  s32x_fb_arbiter #(.ACC_CYC(3), .REF_CYC(40), .AW(AW)) dut (
    .clk_i(clk), .rst_i(rst), .ce_r_i(ce), .ref_req_i(ref_req),
    .disp_req_i(disp_req), .disp_a_i(disp_a), .disp_ack_o(disp_ack), .disp_q_o(disp_q),
    .fill_req_i(fill_req), .fill_a_i(fill_a), .fill_d_i(fill_d), .fill_ack_o(fill_ack),
    .wr_req_i(wr_req), .wr_a_i(wr_a), .wr_d_i(wr_d), .wr_be_i(wr_be), .wr_ovl_i(wr_ovl),
    .wr_ack_o(wr_ack), .rd_req_i(rd_req), .rd_a_i(rd_a), .rd_q_o(rd_q), .rd_ack_o(rd_ack),
    .fb_a_o(fb_a), .fb_do_o(fb_do), .fb_we_o(fb_we), .fb_rd_o(fb_rd), .fb_di_i(fb_di),
    .fen_o(fen)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One falling edge: sample outputs, log acks, and let requesters drop after their ack.
  task automatic step();
    ack_t e;
    @(negedge clk);
    if (ce) tick++;
    if (ce && fb_rd) rd_ticks++;
    if (ce && fen) fen_ticks++;
    if (fen && fb_rd) fen_viol++;
    seen_we = seen_we | fb_we;
    seen_rd = seen_rd | fb_rd;
    if (!rst && (disp_ack || fill_ack || wr_ack || rd_ack)) begin
      e.who  = disp_ack ? 0 : fill_ack ? 1 : wr_ack ? 2 : 3;
      e.a    = fb_a;
      e.q    = disp_ack ? disp_q : rd_q;
      e.dov  = fb_do;
      e.we   = seen_we;
      e.rd   = seen_rd;
      e.tick = tick;
      ackq.push_back(e);
      seen_we = 2'b00;
      seen_rd = 1'b0;
      if (disp_ack && !hold_disp) disp_req = 1'b0;
      if (fill_ack) fill_req = 1'b0;
      if (wr_ack) wr_req = 1'b0;
      if (rd_ack) rd_req = 1'b0;
    end
  endtask

  task automatic wait_acks(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (ackq.size() < n && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (ackq.size() < n) begin
      errors++;
      $display("FAIL %s: timeout with %0d acks, expected %0d", nm, ackq.size(), n);
    end
  endtask

  task automatic pop_ack(output ack_t e);
    if (ackq.size() > 0) e = ackq.pop_front();
    else e = '{who: -1, a: 16'h0, q: 16'h0, dov: 16'h0, we: 2'b00, rd: 1'b0, tick: 0};
  endtask

  wv_t tbl [8];
  ack_t e, e0, e1, e2, ex[$];

  initial begin
    tbl[0] = '{ovl: 1'b1, be: 2'b11, d: 16'h00A5, we: 2'b01};
    tbl[1] = '{ovl: 1'b1, be: 2'b11, d: 16'h0000, we: 2'b00};
    tbl[2] = '{ovl: 1'b0, be: 2'b11, d: 16'h0000, we: 2'b11};
    tbl[3] = '{ovl: 1'b1, be: 2'b11, d: 16'hA500, we: 2'b10};
    tbl[4] = '{ovl: 1'b1, be: 2'b01, d: 16'hA5A5, we: 2'b01};
    tbl[5] = '{ovl: 1'b1, be: 2'b10, d: 16'h00FF, we: 2'b00};
    tbl[6] = '{ovl: 1'b0, be: 2'b10, d: 16'h1234, we: 2'b10};
    tbl[7] = '{ovl: 1'b1, be: 2'b11, d: 16'h8001, we: 2'b11};

    ref_req = 1'b0; disp_req = 1'b0; fill_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    disp_a = '0; fill_a = '0; wr_a = '0; rd_a = '0; fill_d = '0; wr_d = '0;
    wr_be = 2'b00; wr_ovl = 1'b0;
    repeat (4) step();
    chk("rst_fb_a", fb_a, 0);
    chk("rst_fb_do", fb_do, 0);
    chk("rst_strobes", {fb_we, fb_rd, fen}, 0);
    chk("rst_acks", {disp_ack, fill_ack, wr_ack, rd_ack}, 0);
    chk("rst_q", {disp_q, rd_q}, 0);
    rst = 1'b0;
    repeat (3) step();

    // 1: single CPU read
    di_ovr_en = 1'b1; di_ovr = 16'hBEEF; rd_ticks = 0; ackq.delete();
    rd_a = 16'h0100; rd_req = 1'b1;
    wait_acks(1, 200, "t1_ack");
    repeat (10) step();
    chk("t1_ack_count", ackq.size(), 1);
    pop_ack(e);
    chk("t1_who", e.who, 3);
    chk("t1_rd_q", e.q, 16'hBEEF);
    chk("t1_fb_a", e.a, 16'h0100);
    chk("t1_rd_ticks", rd_ticks, 3);
    chk("t1_rd_q_hold", rd_q, 16'hBEEF);
    di_ovr_en = 1'b0;

    // 2: simultaneous DISP/FILL/WR
    for (int k = 0; k < 8 && !ce; k++) step();
    disp_a = 16'h0200; fill_a = 16'h0300; fill_d = 16'h1234;
    wr_a = 16'h0400; wr_d = 16'h5678; wr_be = 2'b11; wr_ovl = 1'b0;
    disp_req = 1'b1; fill_req = 1'b1; wr_req = 1'b1;
    wait_acks(3, 300, "t2_acks");
    pop_ack(e0); pop_ack(e1); pop_ack(e2);
    chk("t2_order", {e0.who[3:0], e1.who[3:0], e2.who[3:0]}, 32'h012);
    chk("t2_disp_q", e0.q, dram_fn(16'h0200));
    chk("t2_fill_we_do", {e1.we, e1.dov}, {2'b11, 16'h1234});
    chk("t2_gap1", e1.tick - e0.tick, 4);
    chk("t2_gap2", e2.tick - e1.tick, 4);

    // 3: write mask table
    for (int i = 0; i < 8; i++) begin
      ackq.delete();
      wr_a = 16'h0500 + 16'(i); wr_d = tbl[i].d; wr_be = tbl[i].be; wr_ovl = tbl[i].ovl;
      wr_req = 1'b1;
      wait_acks(1, 200, $sformatf("t3_ack_%0d", i));
      pop_ack(e);
      chk($sformatf("t3_who_%0d", i), e.who, 2);
      chk($sformatf("t3_we_%0d", i), e.we, tbl[i].we);
      chk($sformatf("t3_do_a_%0d", i), {e.dov, e.a}, {tbl[i].d, 16'h0500 + 16'(i)});
    end

    // 4: refresh requested during a read, display pending behind it
    ackq.delete(); rd_a = 16'h0600; rd_req = 1'b1;
    for (int k = 0; k < 50 && !fb_rd; k++) step();
    ref_req = 1'b1; disp_a = 16'h0700; disp_req = 1'b1; fen_ticks = 0; fen_viol = 0;
    step();
    ref_req = 1'b0;
    wait_acks(2, 600, "t4_acks");
    pop_ack(e0); pop_ack(e1);
    chk("t4_order", {e0.who[3:0], e1.who[3:0]}, 32'h30);
    chk("t4_fen_ticks", fen_ticks, 40);
    chk("t4_no_strobe_in_ref", fen_viol, 0);
    chk("t4_disp_delay", e1.tick - e0.tick, 45);
    chk("t4_disp_q", e1.q, dram_fn(16'h0700));

    // 5: reset in the middle of a fill
    ackq.delete(); fill_a = 16'h0800; fill_d = 16'hCAFE; fill_req = 1'b1;
    for (int k = 0; k < 50 && fb_we !== 2'b11; k++) step();
    for (int k = 0; k < 8 && !ce; k++) step();
    step();
    rst = 1'b1;
    step();
    chk("t5_rst_strobes", {fb_we, fb_rd, fen}, 0);
    chk("t5_rst_q", {disp_q, rd_q}, 0);
    step();
    rst = 1'b0; seen_we = 2'b00; seen_rd = 1'b0;
    chk("t5_no_ack", ackq.size(), 0);
    wait_acks(1, 200, "t5_regrant");
    pop_ack(e);
    chk("t5_fill", {e.who[7:0], e.we, e.dov}, {8'd1, 2'b11, 16'hCAFE});

    // 6: continuous display starves CPU read
    ackq.delete(); hold_disp = 1'b1; disp_a = 16'h0900; rd_a = 16'h0A00;
    disp_req = 1'b1; rd_req = 1'b1;
    wait_acks(5, 400, "t6_acks");
    pop_ack(e0);
    chk("t6_who_0", e0.who, 0);
    for (int i = 1; i < 5; i++) begin
      pop_ack(e1);
      chk($sformatf("t6_who_%0d", i), e1.who, 0);
      chk($sformatf("t6_gap_%0d", i), e1.tick - e0.tick, 4);
      e0 = e1;
    end
    hold_disp = 1'b0; disp_req = 1'b0;
    repeat (40) step();
    e.who = -1;
    while (ackq.size() > 0) pop_ack(e);
    chk("t6_rd_served", e.who, 3);
    chk("t6_rd_q", rd_q, dram_fn(16'h0A00));

    // random bursts against the priority model
    for (int it = 0; it < 24; it++) begin
      int mode;
      logic [3:0] sel;
      bit do_ref;
      mode = $urandom_range(0, 3);
      ce_rand = (mode == 3);
      ce_div = (mode == 3) ? 2 : mode + 1;
      sel = 4'($urandom_range(1, 15));
      do_ref = ($urandom_range(0, 3) == 0);
      disp_a = 16'($urandom); fill_a = 16'($urandom); wr_a = 16'($urandom); rd_a = 16'($urandom);
      fill_d = 16'($urandom); wr_d = 16'($urandom);
      if ($urandom_range(0, 2) == 0) wr_d[15:8] = 8'h00;
      if ($urandom_range(0, 2) == 0) wr_d[7:0] = 8'h00;
      wr_be = 2'($urandom_range(0, 3)); wr_ovl = 1'($urandom_range(0, 1));
      ex.delete();
      if (sel[0]) ex.push_back('{who: 0, a: disp_a, q: dram_fn(disp_a), dov: 16'h0, we: 2'b00, rd: 1'b1, tick: 0});
      if (sel[1]) ex.push_back('{who: 1, a: fill_a, q: 16'h0, dov: fill_d, we: 2'b11, rd: 1'b0, tick: 0});
      if (sel[2]) ex.push_back('{who: 2, a: wr_a, q: 16'h0, dov: wr_d, we: ref_we(wr_be, wr_d, wr_ovl), rd: 1'b0, tick: 0});
      if (sel[3]) ex.push_back('{who: 3, a: rd_a, q: dram_fn(rd_a), dov: 16'h0, we: 2'b00, rd: 1'b1, tick: 0});
      ackq.delete();
      disp_req = sel[0]; fill_req = sel[1]; wr_req = sel[2]; rd_req = sel[3];
      ref_req = do_ref;
      step();
      ref_req = 1'b0;
      wait_acks(ex.size(), 1500, $sformatf("rnd_acks_%0d", it));
      foreach (ex[j]) begin
        pop_ack(e);
        chk($sformatf("rnd_%0d_%0d_who", it, j), e.who, ex[j].who);
        chk($sformatf("rnd_%0d_%0d_a_we_rd", it, j), {e.a, e.we, e.rd}, {ex[j].a, ex[j].we, ex[j].rd});
        if (ex[j].rd) chk($sformatf("rnd_%0d_%0d_q", it, j), e.q, ex[j].q);
        else chk($sformatf("rnd_%0d_%0d_do", it, j), e.dov, ex[j].dov);
      end
      repeat (4) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
